data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the processor's data-memory load/store interface: it accepts one load or store request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the access on an internal little-endian word array, and returns read data or a write acknowledge over a second valid/ready handshake. It sits where the flat combinational data memory sits today. This lets the memory-access stage be tested against a memory with real latency and back-pressure before stall logic is added.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; byte address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: wait states inserted between request accept and response; legal range 0..15.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; asserting low clears all state immediately.
- requestValid  input  1  requester has a request on the request* inputs.
- requestReady  output  1  responder can accept a request this cycle.
- requestWrite  input  1  1 = store, 0 = load.
- requestAddress  input  32  byte address.
- requestFunc3  input  3  RISC-V func3 giving access size and signedness.
- requestWriteData  input  32  store data, right-aligned.
- responseValid  output  1  a response is presented.
- responseReady  input  1  requester accepts the response this cycle.
- responseReadData  output  32  load result, sign- or zero-extended; 0 for stores and errors.
- responseError  output  1  the request was illegal and had no effect.

## Operation
- FSM states:
  - IDLE: requestReady=1. On requestValid, capture write, address, func3 and data; load waitCounter=LATENCY; go to WAIT, or directly to ACCESS when LATENCY=0.
  - WAIT: waitCounter decrements each cycle; go to ACCESS when it reaches 1.
  - ACCESS: one cycle; perform the array read or write; register the response; go to RESPOND.
  - RESPOND: responseValid=1 with data and error held stable; go to IDLE on responseReady.
- requestReady=0 in every state except IDLE. Only one request is outstanding at a time.
- Loads, by func3:
  - 000 LB: byte, sign-extended.
  - 001 LH: halfword, sign-extended.
  - 010 LW: word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
- Stores, by func3:
  - 000 SB: writes requestWriteData[7:0].
  - 001 SH: writes requestWriteData[15:0].
  - 010 SW: writes the full word.
  - Bytes outside the access size are left unchanged.
- Byte lanes are little-endian: address[1:0]=0 selects bits 7:0 of the word at address[31:2].
- Error conditions:
  - Any func3 not listed above for the given direction.
  - address >= 4*DEPTH_WORDS.
  - A misaligned access (see Configuration).
- On error: no array write, responseReadData=0, responseError=1.
- Array contents are not reset; the control state and outputs are.
- Reset asserted in any state: return to IDLE immediately. A store that has not reached ACCESS is discarded. Any pending response is dropped.

## Timing
- Reset values: requestReady=1 after reset is released (state is IDLE); responseValid=0, responseReadData=0, responseError=0.
- Request accepted at edge T → responseValid rises after edge T+1+LATENCY (LATENCY=0: visible in the cycle after accept).
- The response is held for as many cycles as responseReady stays low; data must not change while valid.
- Response handshake at edge R → requestReady=1 in cycle R+1. Minimum request spacing is LATENCY+3 cycles.
- requestValid while requestReady=0 is ignored; the requester must hold it until accepted.
- Store commit: the array is updated at the ACCESS edge. A load issued afterwards observes the new value.

## Configuration
- DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN defined:
  - Halfword access with address[0]=1 is an error.
  - Word access with address[1:0]≠0 is an error.
- Not defined:
  - There is no misalignment error; the ignored low address bits are forced to zero (address[0] for halfword, address[1:0] for word).
  - Range and func3 errors still apply.

## Test plan
- Reset low mid-WAIT during SW 0xDEADBEEF to 0x10 → outputs return to reset values at once; a following LW 0x10 does not return 0xDEADBEEF.
- LATENCY=2: SW 0x8765_4321 to 0x20 accepted at edge T → responseValid=1 after edge T+3 with data 0 and error 0; then LW 0x20 → 0x87654321.
- After that store:
  - LB 0x20 → 0x00000021.
  - LH 0x22 → 0xFFFF8765.
  - LHU 0x22 → 0x00008765.
  - LBU 0x23 → 0x00000087.
- SB 0xAA to 0x21, then LW 0x20 → 0x8765AA21 (other bytes preserved).
- responseReady held low for 5 cycles → responseValid and data stable throughout, requestReady=0, and a new requestValid is not accepted.
- Error cases:
  - LW 0x22 with the macro defined → responseError=1, data 0.
  - LW 0x22 without the macro → returns the word at 0x20.
  - LW 0x400 with DEPTH_WORDS=256 → error.
  - func3=011 → error, with the array unchanged.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the memory-access stage and the data-memory responder.
// The requester uses the master modport; the responder uses the slave modport.
interface data_memory_responder_if;
   logic        requestValid;
   logic        requestReady;
   logic        requestWrite;
   logic [31:0] requestAddress;
   logic [2:0]  requestFunc3;
   logic [31:0] requestWriteData;
   logic        responseValid;
   logic        responseReady;
   logic [31:0] responseReadData;
   logic        responseError;

   modport master (
      output requestValid, requestWrite, requestAddress, requestFunc3, requestWriteData,
      output responseReady,
      input  requestReady, responseValid, responseReadData, responseError
   );

   modport slave (
      input  requestValid, requestWrite, requestAddress, requestFunc3, requestWriteData,
      input  responseReady,
      output requestReady, responseValid, responseReadData, responseError
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one load/store at a time with LATENCY wait states over a word array.
// Define DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN to report misaligned halfword/word accesses.
module data_memory_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input logic                   clock,
   input logic                   reset,
   data_memory_responder_if.slave bus
);

   localparam int unsigned IndexWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StRespond} stateType;

   stateType    stateQ, stateD;
   logic [3:0]  counterQ, counterD;
   logic        writeQ, writeD;
   logic [31:0] addressQ, addressD;
   logic [2:0]  func3Q, func3D;
   logic [31:0] writeDataQ, writeDataD;
   logic [31:0] readDataQ, readDataD;
   logic        errorQ, errorD;

   logic [31:0] memory [DEPTH_WORDS];

   logic                  func3Ok, inRange, misaligned, accessError, memWrite;
   logic [31:0]           effAddress, word, loadValue, storeWord, laneMask, laneData;
   logic [IndexWidth-1:0] index;
   logic [1:0]            lane;
   logic [7:0]            byteValue;
   logic [15:0]           halfValue;

   always_comb begin
      func3Ok = writeQ ? (func3Q inside {3'b000, 3'b001, 3'b010})
                       : (func3Q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      inRange = addressQ < 32'(4 * DEPTH_WORDS);
`ifdef DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN
      misaligned = ((func3Q[1:0] == 2'b01) && addressQ[0]) ||
                   ((func3Q[1:0] == 2'b10) && (addressQ[1:0] != 2'b00));
      effAddress = addressQ;
`else
      misaligned = 1'b0;
      effAddress = addressQ;
      if (func3Q[1:0] == 2'b01) effAddress[0] = 1'b0;
      if (func3Q[1:0] == 2'b10) effAddress[1:0] = 2'b00;
`endif
      accessError = !func3Ok || !inRange || misaligned;

      index     = effAddress[IndexWidth+1:2];
      lane      = effAddress[1:0];
      word      = memory[index];
      byteValue = 8'(word >> {lane, 3'b000});
      halfValue = lane[1] ? word[31:16] : word[15:0];

      unique case (func3Q)
         3'b000:  loadValue = {{24{byteValue[7]}}, byteValue};
         3'b001:  loadValue = {{16{halfValue[15]}}, halfValue};
         3'b010:  loadValue = word;
         3'b100:  loadValue = {24'd0, byteValue};
         3'b101:  loadValue = {16'd0, halfValue};
         default: loadValue = 32'd0;
      endcase

      // Store merge: only the lanes covered by the access size are replaced.
      case (func3Q[1:0])
         2'b00:   laneMask = 32'h0000_00ff << {lane, 3'b000};
         2'b01:   laneMask = 32'h0000_ffff << {lane, 3'b000};
         default: laneMask = 32'hffff_ffff;
      endcase
      laneData  = writeDataQ << {lane, 3'b000};
      storeWord = (word & ~laneMask) | (laneData & laneMask);
      memWrite  = (stateQ == StAccess) && writeQ && !accessError;
   end

   always_comb begin
      stateD     = stateQ;
      counterD   = counterQ;
      writeD     = writeQ;
      addressD   = addressQ;
      func3D     = func3Q;
      writeDataD = writeDataQ;
      readDataD  = readDataQ;
      errorD     = errorQ;
      unique case (stateQ)
         StIdle: begin
            if (bus.requestValid) begin
               writeD     = bus.requestWrite;
               addressD   = bus.requestAddress;
               func3D     = bus.requestFunc3;
               writeDataD = bus.requestWriteData;
               counterD   = 4'(LATENCY);
               stateD     = (LATENCY == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            if (counterQ <= 4'd1) stateD = StAccess;
            else counterD = counterQ - 4'd1;
         end
         StAccess: begin
            readDataD = (writeQ || accessError) ? 32'd0 : loadValue;
            errorD    = accessError;
            stateD    = StRespond;
         end
         StRespond: begin
            if (bus.responseReady) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ     <= StIdle;
         counterQ   <= 4'd0;
         writeQ     <= 1'b0;
         addressQ   <= 32'd0;
         func3Q     <= 3'd0;
         writeDataQ <= 32'd0;
         readDataQ  <= 32'd0;
         errorQ     <= 1'b0;
      end else begin
         stateQ     <= stateD;
         counterQ   <= counterD;
         writeQ     <= writeD;
         addressQ   <= addressD;
         func3Q     <= func3D;
         writeDataQ <= writeDataD;
         readDataQ  <= readDataD;
         errorQ     <= errorD;
      end
   end

   // The array is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (memWrite) memory[index] <= storeWord;
   end

   assign bus.requestReady     = (stateQ == StIdle);
   assign bus.responseValid    = (stateQ == StRespond);
   assign bus.responseReadData = readDataQ;
   assign bus.responseError    = errorQ;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder at default parameters (DEPTH_WORDS=256, LATENCY=2).
module tb_data_memory_responder;

   localparam int ExpLatency = 3;  // cycles from accept edge to first sample with valid high

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } respType;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] wd;
      logic [31:0] expData;
      logic        expErr;
   } reqType;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checkCount = 0;
   int   passCount = 0;
   respType expQueue[$];

   data_memory_responder_if bus ();

   data_memory_responder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output bit ok);
      int waitCycles;
      waitCycles = 0;
      ok = 1'b0;
      lat = 0;
      rd = 32'd0;
      er = 1'b0;
      bus.requestValid = 1'b1;
      bus.requestWrite = wr;
      bus.requestAddress = addr;
      bus.requestFunc3 = f3;
      bus.requestWriteData = wd;
      while (!bus.requestReady && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      if (!bus.requestReady) begin
         bus.requestValid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      bus.requestValid = 1'b0;
      while (!bus.responseValid && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
      if (!bus.responseValid) return;
      rd = bus.responseReadData;
      er = bus.responseError;
      bus.responseReady = 1'b1;
      @(posedge clock); #1;
      bus.responseReady = 1'b0;
      ok = 1'b1;
   endtask

   task automatic runTable(input string name, input reqType tbl[], input bit checkSpacing);
      respType exp;
      logic [31:0] rd;
      logic er;
      int lat;
      bit ok;
      foreach (tbl[i]) begin
         exp.data = tbl[i].expData;
         exp.err = tbl[i].expErr;
         expQueue.push_back(exp);
         issue(tbl[i].wr, tbl[i].addr, tbl[i].f3, tbl[i].wd, rd, er, lat, ok);
         exp = expQueue.pop_front();
         checkCount++;
         if (ok !== 1'b1) $display("FAIL %s[%0d] timeout: completed=%0b want 1", name, i, ok);
         else passCount++;
         checkCount++;
         if (rd !== exp.data) $display("FAIL %s[%0d] data: got %h want %h", name, i, rd, exp.data);
         else passCount++;
         checkCount++;
         if (er !== exp.err) $display("FAIL %s[%0d] error: got %0b want %0b", name, i, er, exp.err);
         else passCount++;
         if (checkSpacing) begin
            checkCount++;
            if (lat !== ExpLatency) $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat,
                                             ExpLatency);
            else passCount++;
            checkCount++;
            if (bus.requestReady !== 1'b1 || bus.responseValid !== 1'b0)
               $display("FAIL %s[%0d] idle after handshake: ready=%0b valid=%0b want 1 0", name, i,
                        bus.requestReady, bus.responseValid);
            else passCount++;
         end
      end
   endtask

   task automatic test_reset();
      bus.requestValid = 1'b0;
      bus.requestWrite = 1'b0;
      bus.requestAddress = 32'd0;
      bus.requestFunc3 = 3'd0;
      bus.requestWriteData = 32'd0;
      bus.responseReady = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      checkCount++;
      if ({bus.requestReady, bus.responseValid, bus.responseReadData, bus.responseError}
          !== {1'b1, 1'b0, 32'd0, 1'b0})
         $display("FAIL reset_values: ready=%0b valid=%0b data=%h err=%0b want 1 0 0 0",
                  bus.requestReady, bus.responseValid, bus.responseReadData, bus.responseError);
      else passCount++;
   endtask

   task automatic test_reset_mid_wait();
      reqType pre[] = new[2];
      reqType post[] = new[1];
      pre[0] = '{1'b1, 32'h10, 3'b010, 32'h1111_1111, 32'd0, 1'b0};
      pre[1] = '{1'b0, 32'h10, 3'b010, 32'd0, 32'h1111_1111, 1'b0};
      runTable("reset_pre", pre, 1'b0);
      bus.requestValid = 1'b1;
      bus.requestWrite = 1'b1;
      bus.requestAddress = 32'h10;
      bus.requestFunc3 = 3'b010;
      bus.requestWriteData = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      bus.requestValid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checkCount++;
      if ({bus.requestReady, bus.responseValid, bus.responseReadData, bus.responseError}
          !== {1'b1, 1'b0, 32'd0, 1'b0})
         $display("FAIL reset_mid_wait: ready=%0b valid=%0b data=%h err=%0b want 1 0 0 0",
                  bus.requestReady, bus.responseValid, bus.responseReadData, bus.responseError);
      else passCount++;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      post[0] = '{1'b0, 32'h10, 3'b010, 32'd0, 32'h1111_1111, 1'b0};
      runTable("reset_post", post, 1'b0);
   endtask

   task automatic test_store_load();
      reqType tbl[] = new[2];
      tbl[0] = '{1'b1, 32'h20, 3'b010, 32'h8765_4321, 32'd0, 1'b0};
      tbl[1] = '{1'b0, 32'h20, 3'b010, 32'd0, 32'h8765_4321, 1'b0};
      runTable("store_load", tbl, 1'b1);
   endtask

   task automatic test_subword();
      reqType tbl[] = new[4];
      tbl[0] = '{1'b0, 32'h20, 3'b000, 32'd0, 32'h0000_0021, 1'b0};
      tbl[1] = '{1'b0, 32'h22, 3'b001, 32'd0, 32'hFFFF_8765, 1'b0};
      tbl[2] = '{1'b0, 32'h22, 3'b101, 32'd0, 32'h0000_8765, 1'b0};
      tbl[3] = '{1'b0, 32'h23, 3'b100, 32'd0, 32'h0000_0087, 1'b0};
      runTable("subword", tbl, 1'b0);
   endtask

   task automatic test_partial_store();
      reqType tbl[] = new[4];
      tbl[0] = '{1'b1, 32'h21, 3'b000, 32'h1234_56AA, 32'd0, 1'b0};
      tbl[1] = '{1'b0, 32'h20, 3'b010, 32'd0, 32'h8765_AA21, 1'b0};
      tbl[2] = '{1'b1, 32'h22, 3'b001, 32'hFFFF_1234, 32'd0, 1'b0};
      tbl[3] = '{1'b0, 32'h20, 3'b010, 32'd0, 32'h1234_AA21, 1'b0};
      runTable("partial_store", tbl, 1'b0);
   endtask

   task automatic test_backpressure();
      reqType tbl[] = new[1];
      logic [31:0] held;
      int waitCycles;
      bus.requestValid = 1'b1;
      bus.requestWrite = 1'b0;
      bus.requestAddress = 32'h20;
      bus.requestFunc3 = 3'b010;
      @(posedge clock); #1;
      // Keep a store pending that must be ignored while the load response is stalled.
      bus.requestWrite = 1'b1;
      bus.requestWriteData = 32'h5555_5555;
      waitCycles = 0;
      while (!bus.responseValid && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      held = bus.responseReadData;
      checkCount++;
      if (held !== 32'h1234_AA21) $display("FAIL stall_data: got %h want %h", held, 32'h1234_AA21);
      else passCount++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
         checkCount++;
         if ({bus.responseValid, bus.requestReady, bus.responseReadData} !== {1'b1, 1'b0, held})
            $display("FAIL stall_cycle%0d: valid=%0b ready=%0b data=%h want 1 0 %h", c,
                     bus.responseValid, bus.requestReady, bus.responseReadData, held);
         else passCount++;
      end
      bus.requestValid = 1'b0;
      bus.responseReady = 1'b1;
      @(posedge clock); #1;
      bus.responseReady = 1'b0;
      tbl[0] = '{1'b0, 32'h20, 3'b010, 32'd0, 32'h1234_AA21, 1'b0};
      runTable("stall_after", tbl, 1'b0);
   endtask

   task automatic test_errors();
      reqType tbl[] = new[10];
`ifdef DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN
      tbl[0] = '{1'b0, 32'h22, 3'b010, 32'd0, 32'd0, 1'b1};
      tbl[1] = '{1'b0, 32'h21, 3'b001, 32'd0, 32'd0, 1'b1};
`else
      tbl[0] = '{1'b0, 32'h22, 3'b010, 32'd0, 32'h1234_AA21, 1'b0};
      tbl[1] = '{1'b0, 32'h21, 3'b001, 32'd0, 32'hFFFF_AA21, 1'b0};
`endif
      tbl[2] = '{1'b0, 32'h400, 3'b010, 32'd0, 32'd0, 1'b1};
      tbl[3] = '{1'b0, 32'h400, 3'b100, 32'd0, 32'd0, 1'b1};
      tbl[4] = '{1'b0, 32'h20, 3'b011, 32'd0, 32'd0, 1'b1};
      tbl[5] = '{1'b0, 32'h20, 3'b110, 32'd0, 32'd0, 1'b1};
      tbl[6] = '{1'b1, 32'h20, 3'b011, 32'hFFFF_FFFF, 32'd0, 1'b1};
      tbl[7] = '{1'b1, 32'h20, 3'b100, 32'hFFFF_FFFF, 32'd0, 1'b1};
      tbl[8] = '{1'b1, 32'h400, 3'b010, 32'hFFFF_FFFF, 32'd0, 1'b1};
      tbl[9] = '{1'b0, 32'h20, 3'b010, 32'd0, 32'h1234_AA21, 1'b0};
      runTable("errors", tbl, 1'b0);
   endtask

   task automatic test_back_to_back();
      reqType tbl[] = new[5];
      tbl[0] = '{1'b1, 32'h3FC, 3'b010, 32'hCAFE_F00D, 32'd0, 1'b0};
      tbl[1] = '{1'b0, 32'h3FC, 3'b010, 32'd0, 32'hCAFE_F00D, 1'b0};
      tbl[2] = '{1'b0, 32'h3FF, 3'b100, 32'd0, 32'h0000_00CA, 1'b0};
      tbl[3] = '{1'b0, 32'h3FF, 3'b000, 32'd0, 32'hFFFF_FFCA, 1'b0};
      tbl[4] = '{1'b0, 32'h3FC, 3'b101, 32'd0, 32'h0000_F00D, 1'b0};
      runTable("back_to_back", tbl, 1'b1);
   endtask

   initial begin
      test_reset();
      test_reset_mid_wait();
      test_store_load();
      test_subword();
      test_partial_store();
      test_backpressure();
      test_errors();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
